// File: rtl/ram_write_burst.sv
// Burst writer: buffers an incoming word stream in a small FIFO and issues
// sequential RAM writes from a latched base address through a WR_LAT-deep pipeline.
module ram_write_burst #(
  parameter int SIZE_DATA  = 8,
  parameter int SIZE_ADDR  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int WR_LAT     = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [SIZE_ADDR-1:0] i_base_addr,
  input  logic [SIZE_ADDR-1:0] i_len,
  input  logic                 i_valid,
  input  logic [SIZE_DATA-1:0] i_data_wr,
  output logic                 o_ready,
  output logic                 o_wr_en,
  output logic [SIZE_ADDR-1:0] o_addr,
  output logic [SIZE_DATA-1:0] o_data_wr,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;

  state_t state_reg, state_next;

  logic [SIZE_ADDR-1:0] len_reg;
  logic [SIZE_ADDR-1:0] acc_reg;
  logic [SIZE_ADDR-1:0] addr_reg;

  logic [SIZE_DATA-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_reg;
  logic [PW-1:0]        rd_ptr_reg;
  logic [PW:0]          count_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drain_last;

  logic [WR_LAT-1:0]    pipe_valid;
  logic [SIZE_ADDR-1:0] pipe_addr [WR_LAT];
  logic [SIZE_DATA-1:0] pipe_data [WR_LAT];

  assign full    = (count_reg == (PW+1)'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign o_ready = (state_reg == BURST) && !full && (acc_reg < len_reg);
  assign push    = i_valid && o_ready;
  assign pop     = ((state_reg == BURST) || (state_reg == DRAIN)) && !empty;

  // Only the output stage holds a word and nothing is left upstream: this is the final write.
  assign drain_last = empty && (pipe_valid == (WR_LAT'(1) << (WR_LAT - 1)));

  assign o_busy = (state_reg != IDLE);
  assign o_done = (state_reg == DONE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          state_next = (i_len == '0) ? DONE : BURST;
        end
      end
      BURST: begin
        if (push && ((acc_reg + 1'b1) == len_reg)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_last) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      len_reg    <= '0;
      acc_reg    <= '0;
      addr_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if ((state_reg == IDLE) && i_start && (i_len != '0)) begin
        len_reg  <= i_len;
        addr_reg <= i_base_addr;
        acc_reg  <= '0;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        acc_reg    <= acc_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        addr_reg   <= addr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage array carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= i_data_wr;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WR_LAT; gi++) begin : g_pipe
      logic                 valid_reg;
      logic [SIZE_ADDR-1:0] addr_stage_reg;
      logic [SIZE_DATA-1:0] data_stage_reg;
      logic                 in_valid;
      logic [SIZE_ADDR-1:0] in_addr;
      logic [SIZE_DATA-1:0] in_data;

      if (gi == 0) begin : g_head
        assign in_valid = pop;
        assign in_addr  = addr_reg;
        assign in_data  = mem[rd_ptr_reg];
      end else begin : g_link
        assign in_valid = pipe_valid[gi-1];
        assign in_addr  = pipe_addr[gi-1];
        assign in_data  = pipe_data[gi-1];
      end

      // Payload only loads with a word, so the last stage holds its value between writes.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          valid_reg      <= 1'b0;
          addr_stage_reg <= '0;
          data_stage_reg <= '0;
        end else begin
          valid_reg <= in_valid;
          if (in_valid) begin
            addr_stage_reg <= in_addr;
            data_stage_reg <= in_data;
          end
        end
      end

      assign pipe_valid[gi] = valid_reg;
      assign pipe_addr[gi]  = addr_stage_reg;
      assign pipe_data[gi]  = data_stage_reg;
    end
  endgenerate

  assign o_wr_en   = pipe_valid[WR_LAT-1];
  assign o_addr    = pipe_addr[WR_LAT-1];
  assign o_data_wr = pipe_data[WR_LAT-1];

endmodule

// File: tb/tb_ram_write_burst.sv
// Directed bench for ram_write_burst: expected writes are queued at burst setup
// and matched in order against the RAM write port.
module tb_ram_write_burst;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic [7:0] i_base_addr;
  logic [7:0] i_len;
  logic       i_valid;
  logic [7:0] i_data_wr;
  logic       o_ready;
  logic       o_wr_en;
  logic [7:0] o_addr;
  logic [7:0] o_data_wr;
  logic       o_busy;
  logic       o_done;

  ram_write_burst dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_len       (i_len),
    .i_valid     (i_valid),
    .i_data_wr   (i_data_wr),
    .o_ready     (o_ready),
    .o_wr_en     (o_wr_en),
    .o_addr      (o_addr),
    .o_data_wr   (o_data_wr),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  int b_wr = 0;
  int b_done = 0;
  int wr_total = 0;
  int done_total = 0;
  int first_wr_cyc = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor, sampled 1 time unit after each rising edge.
  always @(posedge i_clk) begin
    #1;
    if (o_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(o_wr_en), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(o_addr), 32'(mon_e[15:8]));
        check("wr_data", 32'(o_data_wr), 32'(mon_e[7:0]));
      end
      b_wr++;
      wr_total++;
      if (b_wr == 1) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
    end
    if (o_done === 1'b1) begin
      b_done++;
      done_total++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  // Queue expectations, stream len words (optionally every other cycle), wait for o_done.
  task automatic feed(input logic [7:0] base, input logic [7:0] len,
                      input logic [7:0] seed, input bit toggle);
    int k;
    int budget;
    int first_acc;
    int t;
    bit acc;
    logic [7:0] la;
    logic [7:0] ld;
    for (int j = 0; j < int'(len); j++) begin
      exp_q.push_back({8'(base + j), 8'(seed + j)});
    end
    b_wr = 0;
    b_done = 0;
    k = 0;
    budget = 0;
    first_acc = 0;
    while (k < int'(len) && budget < 200) begin
      i_valid   = toggle ? (budget % 2 == 0) : 1'b1;
      i_data_wr = 8'(seed + k);
      acc = i_valid && o_ready;
      step();
      if (acc) begin
        if (k == 0) first_acc = cyc;
        k++;
      end
      budget++;
    end
    i_valid = 1'b0;
    check("accept_count", 32'(k), 32'(len));
    check("ready_after_last", 32'(o_ready), 32'd0);
    t = 0;
    while (b_done == 0 && t < 60) begin
      step();
      t++;
    end
    check("done_seen", 32'(b_done), 32'd1);
    check("write_count", 32'(b_wr), 32'(len));
    check("first_wr_latency", 32'(first_wr_cyc - first_acc), 32'd2);
    check("done_after_last_wr", 32'(done_cyc - last_wr_cyc), 32'd1);
    if (!toggle) check("consecutive_writes", 32'(last_wr_cyc - first_wr_cyc), 32'(len) - 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    la = 8'(base + len - 8'd1);
    ld = 8'(seed + len - 8'd1);
    check("hold_addr", 32'(o_addr), 32'(la));
    check("hold_data", 32'(o_data_wr), 32'(ld));
  endtask

  task automatic do_start(input logic [7:0] base, input logic [7:0] len);
    i_start     = 1'b1;
    i_base_addr = base;
    i_len       = len;
    step();
    i_start = 1'b0;
    check("busy_after_start", 32'(o_busy), 32'd1);
  endtask

  initial begin
    int wr_before;
    int done_before;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_base_addr = '0;
    i_len = '0;
    i_valid = 1'b0;
    i_data_wr = '0;
    repeat (3) step();
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_wr_en", 32'(o_wr_en), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_addr", 32'(o_addr), 32'd0);
    check("rst_data", 32'(o_data_wr), 32'd0);
    i_rst_n = 1'b1;
    step();

    // Basic burst: 0x10..0x13 with data 0xA1..0xA4
    do_start(8'h10, 8'd4);
    feed(8'h10, 8'd4, 8'hA1, 1'b0);
    step();
    check("idle_after_done", 32'(o_busy), 32'd0);

    // Address wrap
    do_start(8'hFE, 8'd3);
    feed(8'hFE, 8'd3, 8'h30, 1'b0);
    step();

    // Zero-length burst
    b_wr = 0;
    i_start = 1'b1;
    i_len = 8'd0;
    i_base_addr = 8'h55;
    step();
    i_start = 1'b0;
    check("len0_busy", 32'(o_busy), 32'd1);
    check("len0_done", 32'(o_done), 32'd1);
    step();
    check("len0_busy_end", 32'(o_busy), 32'd0);
    check("len0_done_end", 32'(o_done), 32'd0);
    repeat (3) step();
    check("len0_no_write", 32'(b_wr), 32'd0);

    // Toggling valid, len 8
    do_start(8'h20, 8'd8);
    feed(8'h20, 8'd8, 8'h60, 1'b1);
    step();

    // Start held high for a whole burst; base changed mid-burst must not matter
    i_start = 1'b1;
    i_base_addr = 8'h80;
    i_len = 8'd2;
    step();
    i_base_addr = 8'h90;
    check("held_busy", 32'(o_busy), 32'd1);
    feed(8'h80, 8'd2, 8'hC0, 1'b0);
    check("held_single_done", 32'(b_done), 32'd1);
    step();
    check("held_idle_gap", 32'(o_busy), 32'd0);
    step();
    check("held_second_start", 32'(o_busy), 32'd1);
    i_start = 1'b0;
    feed(8'h90, 8'd2, 8'hD0, 1'b0);
    step();

    // Reset with two words in flight
    do_start(8'h40, 8'd4);
    i_valid = 1'b1;
    i_data_wr = 8'hE0;
    step();
    i_data_wr = 8'hE1;
    step();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    wr_before = wr_total;
    done_before = done_total;
    step();
    check("mid_rst_wr_en", 32'(o_wr_en), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_ready", 32'(o_ready), 32'd0);
    check("mid_rst_done", 32'(o_done), 32'd0);
    check("mid_rst_addr", 32'(o_addr), 32'd0);
    check("mid_rst_data", 32'(o_data_wr), 32'd0);
    i_rst_n = 1'b1;
    repeat (8) step();
    check("mid_rst_no_wr", 32'(wr_total - wr_before), 32'd0);
    check("mid_rst_no_done", 32'(done_total - done_before), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
